// File: rtl/windowed_watchdog.sv
// Windowed watchdog: WIDTH-bit counter with programmable timeout, early warning
// and an optional early-kick window. Expiry can be locked until rst_n.
module windowed_watchdog #(
  parameter int WIDTH          = 8,
  parameter bit WINDOW_EN      = 1'b1,
  parameter bit LOCK_ON_EXPIRE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             restart,
  input  logic [WIDTH-1:0] tmo_val,
  input  logic [WIDTH-1:0] warn_val,
  input  logic [WIDTH-1:0] win_val,
  output logic             timeout,
  output logic             warning,
  output logic             early_kick,
  output logic [WIDTH-1:0] count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_WARN,
    S_EXPIRED
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_next;
  logic [WIDTH-1:0] r_tmo_q;
  logic [WIDTH-1:0] r_warn_q;
  logic [WIDTH-1:0] r_win_q;
  logic             r_timeout;
  logic             r_warning;
  logic             r_early_kick;
  logic             w_early_next;
  logic             w_capture;
  logic [WIDTH-1:0] w_cnt_inc;
  logic [WIDTH-1:0] w_tmo_eff;
  logic             w_win_open;

  // A zero timeout would never match cnt+1, so it is promoted to one cycle.
  assign w_tmo_eff  = (tmo_val == '0) ? WIDTH'(1) : tmo_val;
  assign w_cnt_inc  = r_cnt + WIDTH'(1);
  assign w_win_open = !WINDOW_EN || (r_cnt >= r_win_q);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_early_next = r_early_kick;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_next   = '0;
        w_early_next = 1'b0;
        if (enable) begin
          w_state_next = S_RUN;
          w_capture    = 1'b1;
        end
      end
      S_RUN, S_WARN: begin
        if (!enable) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
          w_early_next = 1'b0;
        end else if (restart) begin
          if (w_win_open) begin
            w_state_next = S_RUN;
            w_cnt_next   = '0;
            w_capture    = 1'b1;
          end else begin
            w_state_next = S_EXPIRED;
            w_cnt_next   = r_tmo_q;
            w_early_next = 1'b1;
          end
        end else if (w_cnt_inc == r_tmo_q) begin
          w_state_next = S_EXPIRED;
          w_cnt_next   = r_tmo_q;
        end else begin
          w_cnt_next   = w_cnt_inc;
          w_state_next = (w_cnt_inc >= r_warn_q) ? S_WARN : S_RUN;
        end
      end
      S_EXPIRED: begin
        w_cnt_next = r_tmo_q;
        if (!LOCK_ON_EXPIRE) begin
          if (!enable) begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
            w_early_next = 1'b0;
          end else if (restart) begin
            w_state_next = S_RUN;
            w_cnt_next   = '0;
            w_early_next = 1'b0;
            w_capture    = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
        w_early_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_timeout    <= 1'b0;
      r_warning    <= 1'b0;
      r_early_kick <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_timeout    <= (w_state_next == S_EXPIRED);
      r_warning    <= (w_state_next == S_WARN);
      r_early_kick <= w_early_next;
    end
  end

  // Thresholds are frozen for a whole period; mid-period input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_q  <= '0;
      r_warn_q <= '0;
      r_win_q  <= '0;
    end else if (w_capture) begin
      r_tmo_q  <= w_tmo_eff;
      r_warn_q <= warn_val;
      r_win_q  <= win_val;
    end
  end

  assign timeout    = r_timeout;
  assign warning    = r_warning;
  assign early_kick = r_early_kick;
  assign count      = r_cnt;

endmodule

// File: tb/tb_windowed_watchdog.sv
// Directed bench for windowed_watchdog: default, window-disabled and locked
// variants share one stimulus stream and are checked with immediate assertions.
module tb_windowed_watchdog;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       restart;
  logic [7:0] tmo_val;
  logic [7:0] warn_val;
  logic [7:0] win_val;

  logic       d_timeout, d_warning, d_early;
  logic [7:0] d_count;
  logic       n_timeout, n_warning, n_early;
  logic [7:0] n_count;
  logic       l_timeout, l_warning, l_early;
  logic [7:0] l_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  windowed_watchdog #(.WIDTH(8), .WINDOW_EN(1'b1), .LOCK_ON_EXPIRE(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .restart(restart),
    .tmo_val(tmo_val), .warn_val(warn_val), .win_val(win_val),
    .timeout(d_timeout), .warning(d_warning), .early_kick(d_early), .count(d_count)
  );

  windowed_watchdog #(.WIDTH(8), .WINDOW_EN(1'b0), .LOCK_ON_EXPIRE(1'b0)) u_nowin (
    .clk(clk), .rst_n(rst_n), .enable(enable), .restart(restart),
    .tmo_val(tmo_val), .warn_val(warn_val), .win_val(win_val),
    .timeout(n_timeout), .warning(n_warning), .early_kick(n_early), .count(n_count)
  );

  windowed_watchdog #(.WIDTH(8), .WINDOW_EN(1'b1), .LOCK_ON_EXPIRE(1'b1)) u_lock (
    .clk(clk), .rst_n(rst_n), .enable(enable), .restart(restart),
    .tmo_val(tmo_val), .warn_val(warn_val), .win_val(win_val),
    .timeout(l_timeout), .warning(l_warning), .early_kick(l_early), .count(l_count)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic reset_all();
    rst_n   = 1'b0;
    enable  = 1'b0;
    restart = 1'b0;
    tick(2);
    rst_n   = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b0;
    restart  = 1'b0;
    tmo_val  = 8'd10;
    warn_val = 8'd7;
    win_val  = 8'd4;
    tick(2);
    chk("rst_count", d_count, 0);
    chk("rst_timeout", d_timeout, 0);
    chk("rst_warning", d_warning, 0);
    chk("rst_early", d_early, 0);
    rst_n = 1'b1;

    // 1: free-running to expiry
    enable = 1'b1;
    tick();
    chk("t1_entry_count", d_count, 0);
    tick(6);
    chk("t1_e6_count", d_count, 6);
    chk("t1_e6_warning", d_warning, 0);
    tick();
    chk("t1_e7_warning", d_warning, 1);
    chk("t1_e7_count", d_count, 7);
    tick(2);
    chk("t1_e9_timeout", d_timeout, 0);
    chk("t1_e9_warning", d_warning, 1);
    tick();
    chk("t1_e10_timeout", d_timeout, 1);
    chk("t1_e10_warning", d_warning, 0);
    chk("t1_e10_count", d_count, 10);
    tick(20);
    chk("t1_hold_count", d_count, 10);
    chk("t1_hold_timeout", d_timeout, 1);
    reset_all();

    // 2: periodic legal kicks
    enable = 1'b1;
    tick();
    tick(5);
    chk("t2_pre_kick_count", d_count, 5);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("t2_kick_count", d_count, 0);
    chk("t2_kick_warning", d_warning, 0);
    for (int i = 0; i < 16; i++) begin
      tick(5);
      restart = 1'b1;
      tick();
      restart = 1'b0;
      chk("t2_loop_timeout", d_timeout, 0);
    end
    chk("t2_end_count", d_count, 0);
    reset_all();

    // 3: early kick, window enabled vs disabled
    enable = 1'b1;
    tick();
    tick(2);
    chk("t3_pre_count", d_count, 2);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("t3_win_timeout", d_timeout, 1);
    chk("t3_win_early", d_early, 1);
    chk("t3_win_count", d_count, 10);
    chk("t3_nowin_count", n_count, 0);
    chk("t3_nowin_timeout", n_timeout, 0);
    chk("t3_nowin_early", n_early, 0);
    reset_all();

    // 4: kick on the expiry cycle, then disable with simultaneous restart
    enable = 1'b1;
    tick();
    tick(9);
    chk("t4_pre_count", d_count, 9);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("t4_kick_count", d_count, 0);
    chk("t4_kick_timeout", d_timeout, 0);
    tick(6);
    chk("t4_c6_count", d_count, 6);
    enable  = 1'b0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("t4_dis_count", d_count, 0);
    chk("t4_dis_timeout", d_timeout, 0);
    tick();
    chk("t4_idle_count", d_count, 0);
    reset_all();

    // 5: locked expiry and asynchronous reset
    enable = 1'b1;
    tick();
    tick(10);
    chk("t5_lock_expired", l_timeout, 1);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("t5_lock_restart_timeout", l_timeout, 1);
    chk("t5_lock_restart_count", l_count, 10);
    chk("t5_unlocked_restart_count", d_count, 0);
    chk("t5_unlocked_restart_timeout", d_timeout, 0);
    enable = 1'b0;
    tick();
    chk("t5_lock_disable_timeout", l_timeout, 1);
    chk("t5_unlocked_disable_timeout", d_timeout, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_async_timeout", l_timeout, 0);
    chk("t5_async_count", l_count, 0);
    chk("t5_async_warning", l_warning, 0);
    chk("t5_async_early", l_early, 0);
    tick();
    rst_n = 1'b1;
    reset_all();

    // 6a: tmo_val of zero acts as one
    tmo_val = 8'd0;
    enable  = 1'b1;
    tick();
    chk("t6a_entry_timeout", d_timeout, 0);
    tick();
    chk("t6a_timeout", d_timeout, 1);
    chk("t6a_count", d_count, 1);
    reset_all();

    // 6b: warning threshold beyond timeout
    tmo_val  = 8'd10;
    warn_val = 8'd12;
    enable   = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t6b_no_warning", d_warning, 0);
    end
    chk("t6b_timeout", d_timeout, 1);
    chk("t6b_count", d_count, 10);
    reset_all();

    // 6c: tmo_val change mid-period takes effect only after a kick
    warn_val = 8'd7;
    enable   = 1'b1;
    tick();
    tick(3);
    tmo_val = 8'd5;
    tick(3);
    chk("t6c_ignored_count", d_count, 6);
    chk("t6c_ignored_timeout", d_timeout, 0);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("t6c_kick_count", d_count, 0);
    tick(4);
    chk("t6c_c4_timeout", d_timeout, 0);
    tick();
    chk("t6c_new_timeout", d_timeout, 1);
    chk("t6c_new_count", d_count, 5);
    chk("t6c_new_warning", d_warning, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
